// File: rtl/commit_checker_if.sv
// Commit-stream bundle between the lockstep top (master) and commit_checker (slave).
interface commit_checker_if #(
  parameter int DATA_SIZE = 32,
  parameter int REG_BITS  = 5,
  parameter int DEPTH     = 16,
  parameter int CNT_BITS  = 16
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                 enable;
  logic                 stop_on_error;
  logic                 gold_we;
  logic [REG_BITS-1:0]  gold_reg;
  logic [DATA_SIZE-1:0] gold_data;
  logic                 dut_we;
  logic [REG_BITS-1:0]  dut_reg;
  logic [DATA_SIZE-1:0] dut_data;
  logic                 mismatch;
  logic                 error;
  logic [1:0]           fault_code;
  logic [REG_BITS-1:0]  first_reg_gold;
  logic [REG_BITS-1:0]  first_reg_dut;
  logic [DATA_SIZE-1:0] first_data_gold;
  logic [DATA_SIZE-1:0] first_data_dut;
  logic [CNT_BITS-1:0]  match_count;
  logic [CNT_BITS-1:0]  mismatch_count;
  logic [OCC_W-1:0]     occupancy;
  logic                 halted;

  modport master (
    output enable, stop_on_error, gold_we, gold_reg, gold_data, dut_we, dut_reg, dut_data,
    input  mismatch, error, fault_code, first_reg_gold, first_reg_dut, first_data_gold,
           first_data_dut, match_count, mismatch_count, occupancy, halted
  );

  modport slave (
    input  enable, stop_on_error, gold_we, gold_reg, gold_data, dut_we, dut_reg, dut_data,
    output mismatch, error, fault_code, first_reg_gold, first_reg_dut, first_data_gold,
           first_data_dut, match_count, mismatch_count, occupancy, halted
  );
endinterface

// File: rtl/commit_checker.sv
// Lockstep checker: queues golden register-write commits and compares them in order
// against the pipelined core's commits, reporting the first fault and compare counts.
module commit_checker #(
  parameter int DATA_SIZE = 32,
  parameter int REG_BITS  = 5,
  parameter int DEPTH     = 16,
  parameter int MAX_LAG   = 64,
  parameter int CNT_BITS  = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  commit_checker_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam int LW    = $clog2(MAX_LAG + 1);
  localparam int EW    = REG_BITS + DATA_SIZE;

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  state_t               r_state;
  logic [EW-1:0]        r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]     r_count;
  logic [LW-1:0]        r_lag;
  logic                 r_mismatch;
  logic [1:0]           r_fault_code;
  logic [REG_BITS-1:0]  r_first_reg_gold, r_first_reg_dut;
  logic [DATA_SIZE-1:0] r_first_data_gold, r_first_data_dut;
  logic [CNT_BITS-1:0]  r_match_cnt, r_mis_cnt;

  logic                 w_active, w_gv, w_dv, w_empty, w_full;
  logic                 w_bypass, w_pop, w_push, w_overflow, w_orphan, w_timeout;
  logic                 w_cmp, w_miscmp, w_match, w_fault;
  logic [1:0]           w_code;
  logic [EW-1:0]        w_head;
  logic [REG_BITS-1:0]  w_gold_reg;
  logic [DATA_SIZE-1:0] w_gold_data;

  // Commit qualification and FIFO decisions
  always_comb begin
    w_active    = bus.enable && (r_state == ST_RUN);
    w_gv        = w_active && bus.gold_we && (bus.gold_reg != '0);
    w_dv        = w_active && bus.dut_we && (bus.dut_reg != '0);
    w_empty     = (r_count == '0);
    w_full      = (r_count == OCC_W'(DEPTH));
    w_bypass    = w_empty && w_gv && w_dv;
    w_pop       = w_dv && !w_empty;
    w_overflow  = w_gv && w_full && !w_pop;
    w_push      = w_gv && !w_bypass && !w_overflow;
    w_orphan    = w_dv && w_empty && !w_gv;
    w_timeout   = w_active && !w_empty && !w_pop && (r_lag == LW'(MAX_LAG - 1));
    w_head      = r_mem[r_rd_ptr];
    w_gold_reg  = w_bypass ? bus.gold_reg  : w_head[DATA_SIZE +: REG_BITS];
    w_gold_data = w_bypass ? bus.gold_data : w_head[DATA_SIZE-1:0];
    w_cmp       = w_bypass || w_pop;
    w_miscmp    = w_cmp && ((w_gold_reg != bus.dut_reg) || (w_gold_data != bus.dut_data));
    w_match     = w_cmp && !w_miscmp;
    w_fault     = w_miscmp || w_overflow || w_orphan || w_timeout;
    w_code      = 2'd0;
    if (w_miscmp)                    w_code = 2'd1;
    else if (w_overflow || w_orphan) w_code = 2'd2;
    else if (w_timeout)              w_code = 2'd3;
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.gold_reg, bus.gold_data};
  end

  // Registered control, counters and first-fault capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state           <= ST_RUN;
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      r_lag             <= '0;
      r_mismatch        <= 1'b0;
      r_fault_code      <= 2'd0;
      r_first_reg_gold  <= '0;
      r_first_reg_dut   <= '0;
      r_first_data_gold <= '0;
      r_first_data_dut  <= '0;
      r_match_cnt       <= '0;
      r_mis_cnt         <= '0;
    end else begin
      r_mismatch <= w_miscmp;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + OCC_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - OCC_W'(1);
      // Lag saturates at MAX_LAG so the timeout fires once per head entry
      if (w_active) begin
        if (w_pop || w_empty)          r_lag <= '0;
        else if (r_lag != LW'(MAX_LAG)) r_lag <= r_lag + LW'(1);
      end
      if (w_match)  r_match_cnt <= sat_inc(r_match_cnt);
      if (w_miscmp) r_mis_cnt   <= sat_inc(r_mis_cnt);
      if (w_fault && (r_fault_code == 2'd0)) begin
        r_fault_code <= w_code;
        if (w_miscmp) begin
          r_first_reg_gold  <= w_gold_reg;
          r_first_reg_dut   <= bus.dut_reg;
          r_first_data_gold <= w_gold_data;
          r_first_data_dut  <= bus.dut_data;
        end
      end
      if ((r_state == ST_RUN) && w_fault && bus.stop_on_error) r_state <= ST_HALTED;
    end
  end

  assign bus.mismatch        = r_mismatch;
  assign bus.error           = (r_fault_code != 2'd0);
  assign bus.fault_code      = r_fault_code;
  assign bus.first_reg_gold  = r_first_reg_gold;
  assign bus.first_reg_dut   = r_first_reg_dut;
  assign bus.first_data_gold = r_first_data_gold;
  assign bus.first_data_dut  = r_first_data_dut;
  assign bus.match_count     = r_match_cnt;
  assign bus.mismatch_count  = r_mis_cnt;
  assign bus.occupancy       = r_count;
  assign bus.halted          = (r_state == ST_HALTED);
endmodule

// File: tb/tb_commit_checker.sv
// Directed scoreboard bench for commit_checker: stimulus queues expected compare
// results and status snapshots; a negedge monitor pops and checks them.
module tb_commit_checker;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  commit_checker_if #(.DATA_SIZE(32), .REG_BITS(5), .DEPTH(16), .CNT_BITS(16)) bus ();
  commit_checker #(.DATA_SIZE(32), .REG_BITS(5), .DEPTH(16), .MAX_LAG(64), .CNT_BITS(16))
    dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  typedef struct {
    logic        mis;
    logic [15:0] mc;
    logic [15:0] mmc;
  } cmp_t;

  typedef struct {
    logic        mis, err, hal;
    logic [1:0]  fc;
    logic [4:0]  occ;
    logic [15:0] mc, mmc;
    logic [4:0]  frg, frd;
    logic [31:0] fdg, fdd;
  } stat_t;

  cmp_t  cmp_q[$];
  stat_t stat_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cycles = 0;
  bit    done = 1'b0;
  logic [15:0] prev_mc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge CLK) begin
    cycles++;
    if (RESET === 1'b0) begin
      if (bus.mismatch || (bus.match_count == prev_mc + 16'd1)) begin
        if (cmp_q.size() == 0) begin
          chk("unexpected_compare", {bus.match_count, bus.mismatch_count}, {prev_mc, 16'hFFFF});
        end else begin
          cmp_t e;
          e = cmp_q.pop_front();
          chk("cmp_mismatch", 32'(bus.mismatch), 32'(e.mis));
          chk("cmp_match_count", 32'(bus.match_count), 32'(e.mc));
          chk("cmp_mismatch_count", 32'(bus.mismatch_count), 32'(e.mmc));
        end
      end
    end
    prev_mc = bus.match_count;
    while (stat_q.size() != 0) begin
      stat_t s;
      s = stat_q.pop_front();
      chk("mismatch", 32'(bus.mismatch), 32'(s.mis));
      chk("error", 32'(bus.error), 32'(s.err));
      chk("fault_code", 32'(bus.fault_code), 32'(s.fc));
      chk("halted", 32'(bus.halted), 32'(s.hal));
      chk("occupancy", 32'(bus.occupancy), 32'(s.occ));
      chk("match_count", 32'(bus.match_count), 32'(s.mc));
      chk("mismatch_count", 32'(bus.mismatch_count), 32'(s.mmc));
      chk("first_reg_gold", 32'(bus.first_reg_gold), 32'(s.frg));
      chk("first_reg_dut", 32'(bus.first_reg_dut), 32'(s.frd));
      chk("first_data_gold", bus.first_data_gold, s.fdg);
      chk("first_data_dut", bus.first_data_dut, s.fdd);
    end
    if (done || cycles > 20000) begin
      if (!done) chk("watchdog_expired", 32'(cycles), 32'd20000);
      chk("pending_compares", 32'(cmp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic gwe, input logic [4:0] greg, input logic [31:0] gdat,
                       input logic dwe, input logic [4:0] dreg, input logic [31:0] ddat);
    bus.gold_we = gwe; bus.gold_reg = greg; bus.gold_data = gdat;
    bus.dut_we  = dwe; bus.dut_reg  = dreg; bus.dut_data  = ddat;
    tick();
    bus.gold_we = 1'b0; bus.dut_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic exp_cmp(input logic mis, input logic [15:0] mc, input logic [15:0] mmc);
    cmp_t e;
    e.mis = mis; e.mc = mc; e.mmc = mmc;
    cmp_q.push_back(e);
  endtask

  task automatic exp_stat(input logic mis, input logic err, input logic [1:0] fc, input logic hal,
                          input logic [4:0] occ, input logic [15:0] mc, input logic [15:0] mmc,
                          input logic [4:0] frg, input logic [4:0] frd,
                          input logic [31:0] fdg, input logic [31:0] fdd);
    stat_t s;
    s.mis = mis; s.err = err; s.fc = fc; s.hal = hal; s.occ = occ; s.mc = mc; s.mmc = mmc;
    s.frg = frg; s.frd = frd; s.fdg = fdg; s.fdd = fdd;
    stat_q.push_back(s);
  endtask

  initial begin
    RESET = 1'b1;
    bus.enable = 1'b1; bus.stop_on_error = 1'b0;
    bus.gold_we = 1'b0; bus.gold_reg = '0; bus.gold_data = '0;
    bus.dut_we = 1'b0; bus.dut_reg = '0; bus.dut_data = '0;
    tick();
    RESET = 1'b0;
    exp_stat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Lockstep fibonacci, dut three cycles behind
    exp_cmp(0, 1, 0); exp_cmp(0, 2, 0); exp_cmp(0, 3, 0);
    drive(1, 5, 1, 0, 0, 0);
    drive(1, 6, 1, 0, 0, 0);
    drive(1, 7, 2, 0, 0, 0);
    exp_stat(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5, 1);
    drive(0, 0, 0, 1, 6, 1);
    drive(0, 0, 0, 1, 7, 2);
    exp_stat(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    idle(2);

    // Data mismatch with first-fault capture
    do_reset();
    exp_cmp(1, 0, 1);
    drive(1, 7, 32'h3, 0, 0, 0);
    drive(0, 0, 0, 1, 7, 32'h4);
    exp_stat(1, 1, 1, 0, 0, 0, 1, 7, 7, 3, 4);
    tick();
    exp_stat(0, 1, 1, 0, 0, 0, 1, 7, 7, 3, 4);
    idle(1);

    // x0 filtering, then bypass compare on empty FIFO
    do_reset();
    drive(1, 0, 5, 1, 0, 5);
    exp_stat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_cmp(0, 1, 0);
    drive(1, 3, 9, 1, 3, 9);
    exp_stat(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);

    // enable=0 ignores both streams (no push, no orphan)
    do_reset();
    bus.enable = 1'b0;
    drive(1, 8, 8, 0, 0, 0);
    drive(0, 0, 0, 1, 8, 8);
    exp_stat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.enable = 1'b1;
    idle(1);

    // Orphan dut commit
    do_reset();
    drive(0, 0, 0, 1, 3, 1);
    exp_stat(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Overflow, then push+pop while full
    do_reset();
    for (int i = 1; i <= 16; i++) drive(1, 5'(i), 32'(i), 0, 0, 0);
    exp_stat(0, 0, 0, 0, 16, 0, 0, 0, 0, 0, 0);
    drive(1, 17, 17, 0, 0, 0);
    exp_stat(0, 1, 2, 0, 16, 0, 0, 0, 0, 0, 0);
    exp_cmp(0, 1, 0);
    drive(1, 20, 20, 1, 1, 1);
    exp_stat(0, 1, 2, 0, 16, 1, 0, 0, 0, 0, 0);
    idle(1);

    // Timeout after 64 waiting cycles; later pop still compares
    do_reset();
    drive(1, 9, 32'hAB, 0, 0, 0);
    idle(63);
    exp_stat(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    exp_stat(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    exp_cmp(0, 1, 0);
    drive(0, 0, 0, 1, 9, 32'hAB);
    exp_stat(0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);

    // Halt on error, frozen state, reset returns to RUN
    do_reset();
    bus.stop_on_error = 1'b1;
    exp_cmp(1, 0, 1);
    drive(1, 4, 10, 0, 0, 0);
    drive(0, 0, 0, 1, 4, 11);
    exp_stat(1, 1, 1, 1, 0, 0, 1, 4, 4, 10, 11);
    drive(1, 5, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 5, 1);
    drive(1, 6, 6, 1, 6, 6);
    exp_stat(0, 1, 1, 1, 0, 0, 1, 4, 4, 10, 11);
    bus.stop_on_error = 1'b0;
    do_reset();
    exp_stat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_cmp(0, 1, 0);
    drive(1, 2, 2, 1, 2, 2);
    exp_stat(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);

    done = 1'b1;
  end
endmodule
